// File: rtl/fifo.sv
// rtl/fifo.sv - single-clock first-word-fall-through queue with occupancy flags
//
// Holds the address of each outstanding read. The head entry is always
// presented on dout while the queue is non-empty, so a consumer samples dout
// in the same cycle that it asserts rd.
//
// Ports:
//   clk           system clock; all state updates on the rising edge
//   reset         asynchronous active-low reset
//   wr            push request; din captured on the clock edge
//   rd            pop request; removes the current head on the clock edge
//   din           write data [DBITS-1:0]
//   dout          head-of-queue data; 0 when empty
//   full          count == DEPTH
//   empty         count == 0
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   overflow      sticky: wr while full without an accepted rd (FIFO_ERR_FLAGS_EN only)
//   underflow     sticky: rd while empty (FIFO_ERR_FLAGS_EN only)
//
// Build option: define FIFO_ERR_FLAGS_EN to add the overflow/underflow outputs.
module fifo #(
    parameter int DBITS    = 8,
    parameter int ABITS    = 5,
    parameter int AE_LEVEL = 2,
    parameter int AF_LEVEL = (2 ** ABITS) - 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic             rd,
    input  logic [DBITS-1:0] din,
    output logic [DBITS-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
`ifdef FIFO_ERR_FLAGS_EN
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
`else
    output logic             almost_empty
`endif
);

    localparam int DEPTH = 2 ** ABITS;
    localparam logic [ABITS:0] DEPTH_C = (ABITS + 1)'(DEPTH);
    localparam logic [ABITS:0] AF_C    = (ABITS + 1)'(AF_LEVEL);
    localparam logic [ABITS:0] AE_C    = (ABITS + 1)'(AE_LEVEL);

    logic [DBITS-1:0] mem_q [DEPTH];

    logic [ABITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ABITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ABITS:0]   count_q,  count_d;

    logic push;
    logic pop;

    // Flags decode the registered count, so they move the cycle after the edge.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);

    // A pop frees a slot in the same edge, which is what lets a write land
    // on a full queue.
    assign pop  = rd && !empty;
    assign push = wr && (!full || pop);

    // No bypass path: a word written into an empty queue shows up next cycle.
    assign dout = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ABITS'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ABITS'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (ABITS + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (ABITS + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset; empty gating hides stale words.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  || (wr && full && !pop);
        underflow_d = underflow_q || (rd && empty);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo.sv
// tb/tb_fifo.sv - randomized and directed self-checking bench for fifo
module tb_fifo;

    localparam int DBITS = 26;
    localparam int DEPTH = 32;

    logic             clk;
    logic             reset;
    logic             wr;
    logic             rd;
    logic [DBITS-1:0] din;
    logic [DBITS-1:0] dout;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic             overflow;
    logic             underflow;
`endif

    fifo #(.DBITS(DBITS), .ABITS(5)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .rd           (rd),
        .din          (din),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
`ifdef FIFO_ERR_FLAGS_EN
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
`else
        .almost_empty (almost_empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic [DBITS-1:0] model_q[$];
    logic [DBITS-1:0] seq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference queue: decisions come from occupancy before the edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_q.delete();
        end else begin
            bit pop_ok;
            bit push_ok;
            pop_ok  = rd && (model_q.size() > 0);
            push_ok = wr && ((model_q.size() < DEPTH) || pop_ok);
            if (pop_ok)  void'(model_q.pop_front());
            if (push_ok) model_q.push_back(din);
        end
    end

    // Mid-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            int sz;
            sz = model_q.size();
            chk("dout", 32'(dout), (sz == 0) ? 32'h0 : 32'(model_q[0]));
            chk("empty", 32'(empty), 32'(sz == 0));
            chk("full", 32'(full), 32'(sz == DEPTH));
            chk("almost_full", 32'(almost_full), 32'(sz >= DEPTH - 2));
            chk("almost_empty", 32'(almost_empty), 32'(sz <= 2));
        end
    end

    task automatic cyc(input logic w, input logic r, input logic [DBITS-1:0] d);
        wr  = w;
        rd  = r;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (!empty) cyc(1'b0, 1'b1, '0);
        end
        cyc(1'b0, 1'b0, '0);
    endtask

    task automatic mid_reset();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_almost_empty", 32'(almost_empty), 32'h1);
        chk("rst_almost_full", 32'(almost_full), 32'h0);
        chk("rst_dout", 32'(dout), 32'h0);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        din   = '0;
        seq   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        chk_en = 1'b1;
        cyc(1'b0, 1'b0, '0);

        // 1: reset in the middle of a cycle, no clock edge needed
        mid_reset();
        cyc(1'b0, 1'b0, '0);

        // 2: FWFT order
        cyc(1'b1, 1'b0, 26'h000008);
        chk("fwft_first", 32'(dout), 32'h8);
        cyc(1'b1, 1'b0, 26'h000010);
        cyc(1'b1, 1'b0, 26'h000018);
        cyc(1'b0, 1'b0, '0);
        chk("fwft_pop0", 32'(dout), 32'h8);
        cyc(1'b0, 1'b1, '0);
        chk("fwft_pop1", 32'(dout), 32'h10);
        cyc(1'b0, 1'b1, '0);
        chk("fwft_pop2", 32'(dout), 32'h18);
        cyc(1'b0, 1'b1, '0);
        chk("fwft_empty", 32'(empty), 32'h1);
        chk("fwft_dout0", 32'(dout), 32'h0);
        cyc(1'b0, 1'b0, '0);

        // 3: fill, overflow attempt, drain
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, 1'b0, DBITS'(i));
            if (i == 28) chk("af_before", 32'(almost_full), 32'h0);
            if (i == 29) chk("af_after30", 32'(almost_full), 32'h1);
            if (i == 30) chk("full_before", 32'(full), 32'h0);
        end
        chk("full_after32", 32'(full), 32'h1);
        cyc(1'b1, 1'b0, 26'h3FF_FFFF);
        chk("full_after33", 32'(full), 32'h1);
        cyc(1'b0, 1'b0, '0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("overflow", 32'(overflow), 32'h1);
`endif
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", 32'(dout), 32'(i));
            cyc(1'b0, 1'b1, '0);
        end
        chk("drain_empty", 32'(empty), 32'h1);
        cyc(1'b0, 1'b0, '0);

        // 4a: simultaneous rd+wr at count 5
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, DBITS'(100 + i));
        cyc(1'b1, 1'b1, DBITS'(200));
        chk("rw5_head", 32'(dout), 32'd101);
        cyc(1'b1, 1'b1, DBITS'(201));
        cyc(1'b0, 1'b0, '0);
        chk("rw5_head2", 32'(dout), 32'd102);
        drain();

        // 4b: simultaneous rd+wr while full
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, DBITS'(300 + i));
        cyc(1'b1, 1'b1, DBITS'(500));
        cyc(1'b0, 1'b0, '0);
        chk("rwfull_full", 32'(full), 32'h1);
        chk("rwfull_head", 32'(dout), 32'd301);
        drain();

        // 4c: simultaneous rd+wr while empty
        cyc(1'b1, 1'b1, DBITS'(600));
        chk("rwempty_dout", 32'(dout), 32'd600);
        chk("rwempty_empty", 32'(empty), 32'h0);
        drain();

        // 5: alternating bursts of 20 across the pointer wrap
        for (int c = 0; c < 100; c++) begin
            if (((c / 20) % 2) == 0) begin
                cyc(1'b1, 1'b0, seq);
                seq = seq + 1'b1;
            end else begin
                cyc(1'b0, 1'b1, '0);
            end
        end
        drain();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DBITS'($urandom));
        end
        drain();

        // 6: underflow, then reset with data in flight
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, '0);
        chk("underflow_empty", 32'(empty), 32'h1);
`ifdef FIFO_ERR_FLAGS_EN
        chk("underflow", 32'(underflow), 32'h1);
`endif
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, DBITS'(700 + i));
        cyc(1'b0, 1'b0, '0);
        mid_reset();
        cyc(1'b1, 1'b0, 26'h2AA);
        cyc(1'b0, 1'b0, '0);
        chk("post_rst_dout", 32'(dout), 32'h2AA);
        chk("post_rst_empty", 32'(empty), 32'h0);
        chk("post_rst_ae", 32'(almost_empty), 32'h1);
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, '0);
        chk("post_rst_pop", 32'(empty), 32'h1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
